// File: rtl/usb_rcu_param_if.sv
// Receiver-side bundle between the bit-level USB receiver, the RCU and the RX FIFO.
// master drives bus-side strobes and data; slave (the RCU) drives status and FIFO strobe.
interface usb_rcu_param_if #(
   parameter int DATA_W    = 8,
   parameter int MAX_BYTES = 64
);
   localparam int CNT_W = $clog2(MAX_BYTES + 1);

   logic              d_edge;
   logic              eop;
   logic              shift_enable;
   logic [DATA_W-1:0] rcv_data;
   logic              byte_received;
   logic              rcving;
   logic              w_enable;
   logic              r_error;
   logic              pkt_done;
   logic [CNT_W-1:0]  byte_count;

   modport master (
      output d_edge, eop, shift_enable, rcv_data, byte_received,
      input  rcving, w_enable, r_error, pkt_done, byte_count
   );

   modport slave (
      input  d_edge, eop, shift_enable, rcv_data, byte_received,
      output rcving, w_enable, r_error, pkt_done, byte_count
   );
endinterface

// File: rtl/usb_rcu_param.sv
// Parameterised USB receive control unit: sequences sync/PID/data bytes, strobes the
// RX FIFO, checks PID complement, limits packet length and flags partial-byte EOPs.
module usb_rcu_param #(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(8'h80),
   parameter int                MAX_BYTES = 64,
   parameter bit                PID_CHECK = 1'b1
) (
   input logic            clk,
   input logic            rst,
   usb_rcu_param_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_BYTES + 1);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [3:0] {
      IDLE, SYNC, CHK_SYNC, PID_WAIT, CHK_PID, STORE,
      DATA, EOP_WAIT, DONE, ERR, ERR_EOP, ERR_IDLE
   } state_t;

   state_t           state, nxt;
   logic [BIT_W-1:0] bit_cnt;
   logic [CNT_W-1:0] byte_count;
   logic             eop_se;
   logic             byte_aligned;
   logic             sync_entry;
   logic             full;
   logic             pid_ok;

   assign eop_se       = bus.eop & bus.shift_enable;
   assign byte_aligned = (bit_cnt == '0);
   assign sync_entry   = (nxt == SYNC) && (state != SYNC);
   assign full         = (byte_count == CNT_W'(MAX_BYTES));

   // The complement check only makes sense for 8-bit PIDs; other widths always pass.
   if (PID_CHECK && DATA_W == 8) begin : g_pid_chk
      assign pid_ok = (bus.rcv_data[7:4] == ~bus.rcv_data[3:0]);
   end else begin : g_pid_nochk
      assign pid_ok = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (bus.d_edge) nxt = SYNC;
         SYNC:     if (bus.byte_received) nxt = CHK_SYNC;
                   else if (eop_se)       nxt = ERR_EOP;
         CHK_SYNC: nxt = (bus.rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
         PID_WAIT: if (bus.byte_received) nxt = CHK_PID;
                   else if (eop_se)       nxt = ERR_EOP;
         CHK_PID:  nxt = pid_ok ? STORE : ERR;
         STORE:    nxt = DATA;
         // A byte arriving with EOP wins; the EOP is looked at again from DATA.
         DATA:     if (bus.byte_received) nxt = full ? ERR : STORE;
                   else if (eop_se)       nxt = byte_aligned ? EOP_WAIT : ERR_EOP;
         EOP_WAIT: if (bus.d_edge) nxt = DONE;
         DONE:     nxt = IDLE;
         ERR:      if (eop_se) nxt = ERR_EOP;
         ERR_EOP:  if (bus.d_edge) nxt = ERR_IDLE;
         ERR_IDLE: if (bus.d_edge) nxt = SYNC;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bit_cnt <= '0;
      else if (sync_entry || bus.byte_received)
         bit_cnt <= '0;
      else if (bus.shift_enable)
         bit_cnt <= (bit_cnt == BIT_W'(DATA_W - 1)) ? '0 : bit_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         byte_count <= '0;
      else if (sync_entry)
         byte_count <= '0;
      else if (state == STORE && !full)
         byte_count <= byte_count + 1'b1;
   end

   assign bus.rcving     = state inside {SYNC, CHK_SYNC, PID_WAIT, CHK_PID, STORE,
                                         DATA, EOP_WAIT, ERR, ERR_EOP};
   assign bus.r_error    = state inside {ERR, ERR_EOP, ERR_IDLE};
   assign bus.w_enable   = (state == STORE);
   assign bus.pkt_done   = (state == DONE);
   assign bus.byte_count = byte_count;
endmodule

// File: tb/tb_usb_rcu_param.sv
// Bench for usb_rcu_param: two configurations driven in lockstep, packet-level model,
// directed vector table, hand-written timing sequences and randomized packets.
module tb_usb_rcu_param;
   logic       clk = 1'b0;
   logic       rst;
   logic       d_edge, eop, shift_enable, byte_received;
   logic [7:0] rcv_data;

   always #5 clk = ~clk;

   usb_rcu_param_if #(.DATA_W(8), .MAX_BYTES(4)) if0 ();
   usb_rcu_param_if #(.DATA_W(8), .MAX_BYTES(6)) if1 ();

   assign if0.d_edge = d_edge;           assign if1.d_edge = d_edge;
   assign if0.eop = eop;                 assign if1.eop = eop;
   assign if0.shift_enable = shift_enable; assign if1.shift_enable = shift_enable;
   assign if0.rcv_data = rcv_data;       assign if1.rcv_data = rcv_data;
   assign if0.byte_received = byte_received; assign if1.byte_received = byte_received;

   usb_rcu_param #(.DATA_W(8), .SYNC_BYTE(8'h80), .MAX_BYTES(4), .PID_CHECK(1'b1))
      dut0 (.clk(clk), .rst(rst), .bus(if0));
   usb_rcu_param #(.DATA_W(8), .SYNC_BYTE(8'h80), .MAX_BYTES(6), .PID_CHECK(1'b0))
      dut1 (.clk(clk), .rst(rst), .bus(if1));

   typedef struct packed {
      logic [7:0] sync;
      logic [7:0] pid;
      logic [3:0] nd;
      logic       dirty;
   } pkt_t;

   typedef struct packed {
      logic [7:0] w;
      logic [7:0] c;
      logic       e;
      logic       d;
   } res_t;

   typedef struct packed {
      pkt_t p;
      res_t x0;
      res_t x1;
   } vec_t;

   int n_cmp = 0, n_bad = 0;
   int w0 = 0, w1 = 0, p0 = 0, p1 = 0;

   always @(negedge clk) begin
      if (if0.w_enable === 1'b1) w0++;
      if (if1.w_enable === 1'b1) w1++;
      if (if0.pkt_done === 1'b1) p0++;
      if (if1.pkt_done === 1'b1) p1++;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic pulse_edge();
      d_edge = 1'b1; tick(); d_edge = 1'b0;
   endtask

   task automatic send_byte(logic [7:0] b);
      rcv_data = b; byte_received = 1'b1; tick(); byte_received = 1'b0; idle(2);
   endtask

   task automatic send_eop(bit dirty);
      if (dirty) repeat (3) begin
         shift_enable = 1'b1; tick(); shift_enable = 1'b0; tick();
      end
      eop = 1'b1; shift_enable = 1'b1; tick(); eop = 1'b0; shift_enable = 1'b0; idle(2);
   endtask

   // Packet-level outcome from the receive rules: writes, final count, error, done.
   function automatic res_t model(pkt_t p, int maxb, bit pid_chk);
      res_t r;
      int   total;
      r = '0;
      total = 1 + int'(p.nd);
      if (p.sync != 8'h80 || (pid_chk && p.pid[7:4] != ~p.pid[3:0])) begin
         r.e = 1'b1;
      end else if (total > maxb) begin
         r.w = 8'(maxb); r.c = 8'(maxb); r.e = 1'b1;
      end else begin
         r.w = 8'(total); r.c = 8'(total);
         r.e = p.dirty; r.d = !p.dirty;
      end
      return r;
   endfunction

   task automatic run_pkt(string tag, pkt_t p, res_t x0, res_t x1);
      int sw0, sw1, sp0, sp1;
      sw0 = w0; sw1 = w1; sp0 = p0; sp1 = p1;
      pulse_edge();
      chk({tag, " start rcving0"}, if0.rcving, 1);
      chk({tag, " start rerr0"}, if0.r_error, 0);
      chk({tag, " start rcving1"}, if1.rcving, 1);
      chk({tag, " start cnt1"}, if1.byte_count, 0);
      send_byte(p.sync);
      send_byte(p.pid);
      for (int i = 0; i < int'(p.nd); i++) send_byte(8'($urandom));
      send_eop(p.dirty);
      pulse_edge();
      idle(2);
      chk({tag, " writes0"}, w0 - sw0, x0.w);
      chk({tag, " count0"}, if0.byte_count, x0.c);
      chk({tag, " rerr0"}, if0.r_error, x0.e);
      chk({tag, " done0"}, p0 - sp0, x0.d);
      chk({tag, " rcving0"}, if0.rcving, 0);
      chk({tag, " writes1"}, w1 - sw1, x1.w);
      chk({tag, " count1"}, if1.byte_count, x1.c);
      chk({tag, " rerr1"}, if1.r_error, x1.e);
      chk({tag, " done1"}, p1 - sp1, x1.d);
      chk({tag, " rcving1"}, if1.rcving, 0);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, " rcving"}, {if0.rcving, if1.rcving}, 0);
      chk({tag, " w_enable"}, {if0.w_enable, if1.w_enable}, 0);
      chk({tag, " r_error"}, {if0.r_error, if1.r_error}, 0);
      chk({tag, " pkt_done"}, {if0.pkt_done, if1.pkt_done}, 0);
      chk({tag, " byte_count"}, {if0.byte_count, if1.byte_count}, 0);
   endtask

   vec_t tbl[7];

   initial begin
      pkt_t p;
      int   sw;

      // dut0: MAX_BYTES=4, PID check on; dut1: MAX_BYTES=6, PID check off
      tbl[0] = '{'{8'h80, 8'hE1, 4'd2, 1'b0}, '{8'd3, 8'd3, 1'b0, 1'b1}, '{8'd3, 8'd3, 1'b0, 1'b1}};
      tbl[1] = '{'{8'h81, 8'hE1, 4'd2, 1'b0}, '{8'd0, 8'd0, 1'b1, 1'b0}, '{8'd0, 8'd0, 1'b1, 1'b0}};
      tbl[2] = '{'{8'h80, 8'hE0, 4'd0, 1'b0}, '{8'd0, 8'd0, 1'b1, 1'b0}, '{8'd1, 8'd1, 1'b0, 1'b1}};
      tbl[3] = '{'{8'h80, 8'hE1, 4'd0, 1'b1}, '{8'd1, 8'd1, 1'b1, 1'b0}, '{8'd1, 8'd1, 1'b1, 1'b0}};
      tbl[4] = '{'{8'h80, 8'hE1, 4'd4, 1'b0}, '{8'd4, 8'd4, 1'b1, 1'b0}, '{8'd5, 8'd5, 1'b0, 1'b1}};
      tbl[5] = '{'{8'h80, 8'hD2, 4'd6, 1'b0}, '{8'd4, 8'd4, 1'b1, 1'b0}, '{8'd6, 8'd6, 1'b1, 1'b0}};
      tbl[6] = '{'{8'h80, 8'hC3, 4'd1, 1'b1}, '{8'd2, 8'd2, 1'b1, 1'b0}, '{8'd2, 8'd2, 1'b1, 1'b0}};

      rst = 1'b1; d_edge = 0; eop = 0; shift_enable = 0; byte_received = 0; rcv_data = 8'h00;
      idle(3);
      chk_zero("reset");
      rst = 1'b0;
      idle(2);
      chk_zero("post-reset");

      // write latency for PID and data bytes, byte_received priority over EOP
      pulse_edge();
      send_byte(8'h80);
      rcv_data = 8'hE1; byte_received = 1'b1; tick(); byte_received = 1'b0;
      chk("pid lat+1 w_enable", if0.w_enable, 0);
      tick();
      chk("pid lat+2 w_enable", if0.w_enable, 1);
      tick();
      rcv_data = 8'h12; byte_received = 1'b1; tick(); byte_received = 1'b0;
      chk("data lat+1 w_enable", {if0.w_enable, if1.w_enable}, 2'b11);
      tick();
      rcv_data = 8'h34; byte_received = 1'b1; eop = 1'b1; shift_enable = 1'b1; tick();
      byte_received = 1'b0; eop = 1'b0; shift_enable = 1'b0;
      chk("byte beats eop w_enable", if0.w_enable, 1);
      tick();
      eop = 1'b1; shift_enable = 1'b1; tick(); eop = 1'b0; shift_enable = 1'b0;
      chk("eop_wait rcving", if0.rcving, 1);
      chk("eop_wait pkt_done", if0.pkt_done, 0);
      pulse_edge();
      chk("done pkt_done", {if0.pkt_done, if1.pkt_done}, 2'b11);
      chk("done rcving", if0.rcving, 0);
      chk("done count", if0.byte_count, 3);
      tick();
      chk("idle pkt_done", if0.pkt_done, 0);
      chk("idle count hold", if0.byte_count, 3);

      // bad sync: error appears after the check cycle, clears on restart
      pulse_edge();
      rcv_data = 8'h81; byte_received = 1'b1; tick(); byte_received = 1'b0;
      chk("chk_sync r_error", if0.r_error, 0);
      tick();
      chk("err r_error", if0.r_error, 1);
      chk("err rcving", if0.rcving, 1);
      send_eop(1'b0);
      pulse_edge();
      chk("err_idle rcving", if0.rcving, 0);
      chk("err_idle r_error", if0.r_error, 1);
      pulse_edge();
      chk("restart r_error", if0.r_error, 0);
      chk("restart rcving", if0.rcving, 1);
      rst = 1'b1; tick(); rst = 1'b0; tick();

      // reset mid-packet, then a fresh packet
      pulse_edge();
      send_byte(8'h80); send_byte(8'hE1); send_byte(8'h11); send_byte(8'h22);
      chk("pre-reset count", if0.byte_count, 3);
      sw = w0;
      rst = 1'b1; #1;
      chk_zero("mid-reset");
      idle(2);
      chk("no write in reset", w0 - sw, 0);
      rst = 1'b0; tick();
      p = '{8'h80, 8'hE1, 4'd0, 1'b0};
      run_pkt("fresh", p, model(p, 4, 1'b1), model(p, 6, 1'b0));

      for (int i = 0; i < 7; i++)
         run_pkt($sformatf("vec%0d", i), tbl[i].p, tbl[i].x0, tbl[i].x1);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] lo;
         lo = 4'($urandom);
         p.sync  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h80;
         p.pid   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {~lo, lo};
         p.nd    = 4'($urandom_range(0, 7));
         p.dirty = ($urandom_range(0, 3) == 0);
         run_pkt($sformatf("rnd%0d", i), p, model(p, 4, 1'b1), model(p, 6, 1'b0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/usb_rcu_param.md
Name: usb_rcu_param

Overview:
Parameterised USB receiver control unit; the successor to the fixed 8-bit RCU. It sits between the bit-level receiver (edge detect, EOP detect, shift register) and the RX FIFO. It sequences sync, PID and data bytes, and generates FIFO write strobes. Unlike the fixed RCU, it also does PID complement checking, partial-byte EOP detection via an internal bit counter, packet-length limiting with overflow error, and a packet-done pulse with final byte count.

Parameters:
DATA_W, 8, width of rcv_data and bits per byte (bit counter wraps at DATA_W)
SYNC_BYTE, 8'h80, required first byte; width DATA_W
MAX_BYTES, 64, max bytes written per packet (PID plus data); must be at least 1
PID_CHECK, 1, 1 requires rcv_data[7:4] == ~rcv_data[3:0] on the PID byte; 0 skips the check (only meaningful when DATA_W = 8)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
d_edge  in  1  single-cycle pulse, D+/D- transition detected
eop  in  1  EOP condition present on bus
shift_enable  in  1  single-cycle pulse per bit-sample instant
rcv_data  in  DATA_W  byte from shift register; valid when byte_received is high
byte_received  in  1  single-cycle pulse, full byte assembled
rcving  out  1  packet reception in progress
w_enable  out  1  FIFO write strobe, one cycle per accepted byte
r_error  out  1  receive error flag, sticky until next packet start
pkt_done  out  1  one-cycle pulse on clean packet completion
byte_count  out  $clog2(MAX_BYTES+1)  bytes written in current or last packet

Behaviour:
- Moore FSM; all outputs are registered or decoded from the state register. No output depends combinationally on inputs.
- Reset (async, rst=1): state=IDLE, bit_cnt=0, byte_count=0, rcving=0, w_enable=0, r_error=0, pkt_done=0. Reset mid-packet aborts with no further w_enable.
- bit_cnt: cleared on entry to SYNC and on byte_received; otherwise increments on shift_enable, wrapping modulo DATA_W.
- "Clean EOP" = eop & shift_enable & bit_cnt==0. "Dirty EOP" = eop & shift_enable & bit_cnt!=0.
- IDLE: d_edge -> SYNC. On entry to SYNC: rcving=1, r_error=0, byte_count=0.
- SYNC: byte_received -> CHK_SYNC. Any eop & shift_enable -> ERR_EOP.
- CHK_SYNC (1 cycle): rcv_data==SYNC_BYTE -> PID_WAIT; otherwise -> ERR.
- PID_WAIT: byte_received -> CHK_PID. Any eop & shift_enable -> ERR_EOP.
- CHK_PID (1 cycle): check fails (with PID_CHECK=1) -> ERR. Otherwise -> STORE.
- DATA: byte_received & byte_count==MAX_BYTES -> ERR (no write). byte_received otherwise -> STORE. Clean EOP -> EOP_WAIT. Dirty EOP -> ERR_EOP.
- STORE (1 cycle): w_enable=1, byte_count++, -> DATA. w_enable is asserted exactly 2 cycles after the byte_received pulse for the PID, and 1 cycle after it for data bytes.
- EOP_WAIT: d_edge (bus returns to idle) -> DONE.
- DONE (1 cycle): pkt_done=1, rcving=0, -> IDLE.
- ERR: r_error=1, rcving=1; eop & shift_enable -> ERR_EOP.
- ERR_EOP: d_edge -> ERR_IDLE.
- ERR_IDLE: rcving=0, r_error held at 1; d_edge -> SYNC, which clears r_error.
- Simultaneous byte_received and eop & shift_enable in DATA: byte_received has priority; EOP is reevaluated next cycle.
- byte_count saturates at MAX_BYTES and holds its value after DONE or error until the next entry to SYNC.
- w_enable is never asserted in any state other than STORE.

Test Plan:
1. Clean packet: sync 0x80, PID 0xE1, data 0x12, 0x34, then clean EOP and d_edge -> w_enable pulses 3 times, byte_count=3, pkt_done pulses once, r_error=0, rcving falls in DONE.
2. Bad sync: first byte 0x81 -> no w_enable, r_error=1 one cycle after CHK_SYNC; after EOP and two d_edges, r_error clears and rcving=1.
3. Bad PID: sync 0x80, PID 0xE0 with PID_CHECK=1 -> r_error=1, byte_count=0. The same PID with PID_CHECK=0 -> accepted, byte_count=1.
4. Dirty EOP: after the PID, 3 shift_enable pulses then eop & shift_enable -> ERR_EOP, r_error=1, no pkt_done.
5. Overflow (MAX_BYTES=4): PID plus 4 data bytes -> 4 w_enable pulses, 5th byte_received -> r_error=1, byte_count stays 4.
6. Reset mid-packet: rst asserted after the 2nd data byte -> all outputs 0 immediately; the next d_edge starts a fresh packet with byte_count=0.
